// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//
// Spike-train rate decoder. Counts spikes per channel over fixed windows of
// WIN_TICKS enabled clock ticks. At each window close the counts are
// snapshotted into shadow registers and streamed out one channel per beat on
// a valid/ready interface.
//
// Optional feature macro: SPIKE_DEC_EMA_EN
//   Defined     -> per-channel exponential moving average of the accepted
//                  counts, unsigned fixed point (W bits, Q fractional bits),
//                  presented on out_ema alongside each beat.
//   Not defined -> no EMA state; out_ema is tied to 0.
//
// Parameters
//   N_CH      number of spike channels
//   WIN_TICKS window length in enabled ticks (>= 2)
//   CNT_W     per-channel count width; counts saturate at 2^CNT_W-1
//   EMA_SHIFT EMA smoothing shift (EMA build only)
//   W, Q      EMA word width / fractional bits, matching the LIF fixed-point
//             format used by the neuron datapath
//
// Ports
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   en          1: advance tick counter and count spikes; 0: hold window
//   spikes      one bit per channel, sampled while en=1
//   out_valid   snapshot beat available
//   out_ready   consumer accepts beat
//   out_ch      channel index of the current beat
//   out_count   snapshotted count for out_ch
//   out_last    current beat is channel N_CH-1
//   out_ema     smoothed count for out_ch (0 without the EMA build)
//   win_done    one-cycle pulse the cycle after each window close
//   overrun     sticky: a snapshot was dropped because a drain was in flight
//   clr_overrun clears overrun (a simultaneous new overrun wins)

module spike_rate_decoder #(
    parameter int N_CH      = 2,
    parameter int WIN_TICKS = 1000,
    parameter int CNT_W     = 16,
    parameter int EMA_SHIFT = 3,
    parameter int W         = 16,
    parameter int Q         = 8,
    localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_CH-1:0]  spikes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_ch,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic [W-1:0]     out_ema,
    output logic             win_done,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int               TICK_W    = $clog2(WIN_TICKS);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(WIN_TICKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [CNT_W-1:0]  cnt_reg    [N_CH];
    logic [CNT_W-1:0]  cnt_next   [N_CH];
    logic [CNT_W-1:0]  cnt_inc    [N_CH];
    logic [CNT_W-1:0]  shadow_reg [N_CH];
    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              win_done_reg;
    logic              overrun_reg;

    logic close;
    logic handshake;
    logic last_beat;
    logic accept_snap;
    logic drop_snap;

    assign close       = en && (tick_reg == LAST_TICK);
    assign handshake   = (state_reg == SEND) && out_ready;
    assign last_beat   = handshake && (idx_reg == LAST_IDX);
    // A close landing on the final handshake hands over straight into the
    // next burst, so only a close during a mid-drain beat is dropped.
    assign accept_snap = close && ((state_reg == IDLE) || last_beat);
    assign drop_snap   = close && !accept_snap;

    // ---------------------------------------------------------------- ticks
    always_comb begin
        tick_next = tick_reg;
        if (en) begin
            tick_next = close ? '0 : tick_reg + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_next;
        end
    end

    // ---------------------------------------------------- live / shadow counts
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cnt
            // cnt_inc includes the spike of the current edge, so on the close
            // edge it is the final count of the closing window.
            always_comb begin
                cnt_inc[gi] = cnt_reg[gi];
                if (spikes[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_inc[gi] = cnt_reg[gi] + CNT_W'(1);
                end
            end

            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (en) begin
                    cnt_next[gi] = close ? '0 : cnt_inc[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi]    <= '0;
                    shadow_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                    if (accept_snap) begin
                        shadow_reg[gi] <= cnt_inc[gi];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------- drain FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (handshake) begin
            if (idx_reg == LAST_IDX) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                idx_next = idx_reg + IDX_W'(1);
            end
        end
        if (accept_snap) begin
            state_next = SEND;
            idx_next   = '0;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_ch    = '0;
        out_count = '0;
        out_last  = 1'b0;
        if (state_reg == SEND) begin
            out_valid = 1'b1;
            out_ch    = idx_reg;
            out_count = shadow_reg[idx_reg];
            out_last  = (idx_reg == LAST_IDX);
        end
    end

    // --------------------------------------------------------- status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_done_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            win_done_reg <= close;
            if (drop_snap) begin
                overrun_reg <= 1'b1;
            end else if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign win_done = win_done_reg;
    assign overrun  = overrun_reg;

    // ------------------------------------------------------------------- EMA
`ifdef SPIKE_DEC_EMA_EN
    // Intermediate width holds count<<Q or the EMA plus a sign and guard bit.
    localparam int DW = (((CNT_W + Q) > W) ? (CNT_W + Q) : W) + 2;
    localparam logic signed [DW-1:0] EMA_MAX = DW'((64'd1 << W) - 64'd1);

    logic [W-1:0] ema_reg  [N_CH];
    logic [W-1:0] ema_next [N_CH];

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ema
            logic [DW-1:0]        tgt_u;
            logic [DW-1:0]        cur_u;
            logic signed [DW-1:0] diff_s;
            logic signed [DW-1:0] sum_s;

            always_comb begin
                tgt_u  = DW'(cnt_inc[gi]) << Q;
                cur_u  = DW'(ema_reg[gi]);
                diff_s = $signed(tgt_u) - $signed(cur_u);
                sum_s  = $signed(cur_u) + (diff_s >>> EMA_SHIFT);
                if (sum_s < 0) begin
                    ema_next[gi] = '0;
                end else if (sum_s > EMA_MAX) begin
                    ema_next[gi] = '1;
                end else begin
                    ema_next[gi] = sum_s[W-1:0];
                end
            end

            // Only accepted snapshots feed the average.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ema_reg[gi] <= '0;
                end else if (accept_snap) begin
                    ema_reg[gi] <= ema_next[gi];
                end
            end
        end
    endgenerate

    assign out_ema = (state_reg == SEND) ? ema_reg[idx_reg] : '0;
`else
    assign out_ema = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    localparam int N_CH  = 2;
    localparam int WIN   = 8;
    localparam int CNT_W = 16;
    localparam int EMA_S = 1;
    localparam int W_E   = 16;
    localparam int Q_E   = 8;
`ifdef SPIKE_DEC_EMA_EN
    localparam logic [W_E-1:0] SAT_EMA = 16'd896;   // (7<<8)>>>1 from zero
`else
    localparam logic [W_E-1:0] SAT_EMA = 16'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [N_CH-1:0]  spikes = '0;
    logic             out_ready = 1'b0;
    logic             clr_overrun = 1'b0;
    logic             out_valid;
    logic [0:0]       out_ch;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic [W_E-1:0]   out_ema;
    logic             win_done;
    logic             overrun;

    // Saturation instance: 16-tick window, 3-bit counts.
    logic             sat_en = 1'b0;
    logic [1:0]       sat_spikes = '0;
    logic             sat_out_ready = 1'b1;
    logic             sat_clr = 1'b0;
    logic             sat_out_valid;
    logic [0:0]       sat_out_ch;
    logic [2:0]       sat_out_count;
    logic             sat_out_last;
    logic [W_E-1:0]   sat_out_ema;
    logic             sat_win_done;
    logic             sat_overrun;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .N_CH(N_CH), .WIN_TICKS(WIN), .CNT_W(CNT_W),
        .EMA_SHIFT(EMA_S), .W(W_E), .Q(Q_E)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spikes(spikes),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_count(out_count), .out_last(out_last), .out_ema(out_ema),
        .win_done(win_done), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    spike_rate_decoder #(
        .N_CH(2), .WIN_TICKS(16), .CNT_W(3),
        .EMA_SHIFT(EMA_S), .W(W_E), .Q(Q_E)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .en(sat_en), .spikes(sat_spikes),
        .out_valid(sat_out_valid), .out_ready(sat_out_ready), .out_ch(sat_out_ch),
        .out_count(sat_out_count), .out_last(sat_out_last), .out_ema(sat_out_ema),
        .win_done(sat_win_done), .overrun(sat_overrun), .clr_overrun(sat_clr)
    );

    typedef struct {
        logic [7:0] m0;
        logic [7:0] m1;
        int         exp0;
        int         exp1;
    } vec_t;

    typedef struct {
        int ch;
        int cnt;
        bit last;
        int ema;
    } beat_t;

    beat_t sb_q[$];
    int    ema_m[2];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic int ema_step(input int e, input int cnt);
`ifdef SPIKE_DEC_EMA_EN
        int r;
        r = e + (((cnt << Q_E) - e) >>> EMA_S);
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
        return r;
`else
        return 0 + (e & 0) + (cnt & 0);
`endif
    endfunction

    task automatic push_window(input int c0, input int c1);
        beat_t b;
        for (int ch = 0; ch < 2; ch++) begin
            b.cnt   = (ch == 0) ? c0 : c1;
            ema_m[ch] = ema_step(ema_m[ch], b.cnt);
            b.ch    = ch;
            b.last  = (ch == 1);
            b.ema   = ema_m[ch];
            sb_q.push_back(b);
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({out_valid, out_ch, out_count, out_last, out_ema, win_done, overrun});
    endfunction

    // One enabled/disabled tick: inputs set after an edge, sampled at the next.
    task automatic drive(input logic e, input logic [1:0] s, input logic rdy, input logic clr);
        en          = e;
        spikes      = s;
        out_ready   = rdy;
        clr_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_window(input logic [7:0] m0, input logic [7:0] m1,
                                input logic [7:0] rdy, input logic clr_last,
                                input int lo, input int hi);
        for (int t = lo; t <= hi; t++) begin
            drive(1'b1, {m1[t], m0[t]}, rdy[t], (t == 7) ? clr_last : 1'b0);
        end
    endtask

    // Scoreboard consumer: every handshake pops one expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beat_t b;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got ch=%0d count=%0d, required no beat", out_ch, out_count);
            end else begin
                b = sb_q.pop_front();
                if (out_ch !== b.ch[0] || out_count !== b.cnt[CNT_W-1:0] ||
                    out_last !== b.last || out_ema !== b.ema[W_E-1:0]) begin
                    n_fail++;
                    $display("FAIL beat: got ch=%0d count=%0d last=%0d ema=%0d, required ch=%0d count=%0d last=%0d ema=%0d",
                             out_ch, out_count, out_last, out_ema, b.ch, b.cnt, b.last, b.ema);
                end else begin
                    $display("beat ch=%0d count=%0d last=%0d ema=%0d", out_ch, out_count, out_last, out_ema);
                end
            end
        end
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'hFF, 8'h55, 8, 4};
        vecs[1] = '{8'h00, 8'h00, 0, 0};
        vecs[2] = '{8'h01, 8'h80, 1, 1};
        vecs[3] = '{8'hF0, 8'hFF, 4, 8};
        vecs[4] = '{8'hAA, 8'h07, 4, 3};
        vecs[5] = '{8'h3C, 8'hC3, 4, 4};
        ema_m[0] = 0;
        ema_m[1] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Basic rates with timing of valid / win_done
        drive_window(8'hFF, 8'h55, 8'hFF, 1'b0, 0, 6);
        check("basic_no_early_valid", 64'(out_valid), 64'd0);
        drive_window(8'hFF, 8'h55, 8'hFF, 1'b0, 7, 7);
        push_window(8, 4);
        check("basic_T1", 64'({out_valid, win_done, out_ch, out_last}), 64'b1100);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("basic_T2", 64'({out_valid, win_done, out_ch, out_last}), 64'b1011);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("basic_T3_drop", 64'({out_valid, win_done}), 64'd0);

        // Table of windows streamed back to back with ready held
        for (int v = 0; v < 6; v++) begin
            drive_window(vecs[v].m0, vecs[v].m1, 8'hFF, 1'b0, 0, 7);
            push_window(vecs[v].exp0, vecs[v].exp1);
        end
        repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("table_drained", 64'(sb_q.size()), 64'd0);

        // Backpressure across two closes, overrun set / clear / set-wins
        drive_window(8'h0F, 8'h01, 8'h00, 1'b0, 0, 7);
        push_window(4, 1);
        check("bp_first_beat", 64'({out_valid, out_ch, out_count}), 64'({1'b1, 1'b0, 16'd4}));
        check("bp_no_overrun_yet", 64'(overrun), 64'd0);
        drive_window(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 7);
        check("bp_overrun_set", 64'(overrun), 64'd1);
        check("bp_held_stable", 64'({out_valid, out_ch, out_count, out_last}), 64'({1'b1, 1'b0, 16'd4, 1'b0}));
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        check("bp_overrun_clr", 64'(overrun), 64'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        drive_window(8'hFF, 8'hFF, 8'h00, 1'b1, 0, 7);
        check("bp_set_wins", 64'(overrun), 64'd1);
        repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("bp_released_idle", 64'(out_valid), 64'd0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        check("bp_final_clr", 64'(overrun), 64'd0);

        // Last handshake coinciding with a close
        drive_window(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 7);
        push_window(8, 8);
        drive_window(8'h33, 8'hFF, 8'hC0, 1'b0, 0, 6);
        check("b2b_before_close", 64'({out_valid, out_ch}), 64'b11);
        drive_window(8'h33, 8'hFF, 8'hC0, 1'b0, 7, 7);
        push_window(4, 8);
        check("b2b_after_close", 64'({out_valid, out_ch, overrun, win_done}), 64'b1001);
        repeat (2) drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("b2b_drained", 64'({out_valid, overrun}), 64'd0);

        // en hold for 5 cycles mid-window shifts count and close by 5
        drive_window(8'hFF, 8'hFF, 8'hFF, 1'b0, 0, 3);
        repeat (5) drive(1'b0, 2'b11, 1'b1, 1'b0);
        drive_window(8'hFF, 8'hFF, 8'hFF, 1'b0, 4, 6);
        check("hold_no_early_close", 64'({out_valid, win_done}), 64'd0);
        drive_window(8'hFF, 8'hFF, 8'hFF, 1'b0, 7, 7);
        push_window(8, 8);
        check("hold_close", 64'({out_valid, win_done}), 64'b11);
        repeat (2) drive(1'b0, 2'b00, 1'b1, 1'b0);

        // Saturation on the 3-bit instance
        sat_en     = 1'b1;
        sat_spikes = 2'b11;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        check("sat_no_early_valid", 64'(sat_out_valid), 64'd0);
        @(posedge clk);
        #1;
        sat_en = 1'b0;
        check("sat_beat0", 64'({sat_out_valid, sat_out_ch, sat_out_count, sat_out_last, sat_win_done}),
              64'({1'b1, 1'b0, 3'd7, 1'b0, 1'b1}));
        check("sat_aux", 64'({sat_overrun, sat_out_ema}), 64'({1'b0, SAT_EMA}));
        @(posedge clk);
        #1;
        check("sat_beat1", 64'({sat_out_valid, sat_out_ch, sat_out_count, sat_out_last}),
              64'({1'b1, 1'b1, 3'd7, 1'b1}));
        @(posedge clk);
        #1;
        check("sat_done", 64'(sat_out_valid), 64'd0);

        // Asynchronous reset mid-burst, then a fresh full window
        drive_window(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 7);
        check("rst_burst_started", 64'(out_valid), 64'd1);
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_burst", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        ema_m[0] = 0;
        ema_m[1] = 0;
        drive_window(8'hFF, 8'h00, 8'hFF, 1'b0, 0, 6);
        check("rst_no_early_valid", 64'(out_valid), 64'd0);
        drive_window(8'hFF, 8'h00, 8'hFF, 1'b0, 7, 7);
        push_window(8, 0);
        check("rst_first_valid", 64'({out_valid, win_done}), 64'b11);
        repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
